uart_rx_display: RTL and testbench
==================================

// Module: uart_rx_display
// PURPOSE
//   8N1 UART receiver that supplies the 16-bit value shown on the 4-digit hex LED display.
//   Sits between the board RX pin and the display driver. Each good byte shifts into num:
//   the last two bytes show as 4 hex digits, with the older byte in num[15:8].
//   Also flags framing errors and reports when a frame is in progress.
// PARAMETERS
//   CLK_FREQ   100_000_000  system clock frequency in Hz (10 ns period)
//   BAUD       9600         line rate in bit/s
//   OVERSAMPLE 16           ticks per bit (fixed; comes from the shared header)
// PORTS
//   clk        in   1   system clock; all state updates on its rising edge
//   rst_n      in   1   reset; asynchronous assert, active-low
//   rx         in   1   asynchronous serial line; idles high
//   num        out  16  display word {previous byte, latest byte}; feeds the hex display
//   byte_valid out  1   one-clk pulse when a good byte enters num
//   frame_err  out  1   sticky; set on a bad stop bit, cleared by the next good byte
//   busy       out  1   high while a frame is in progress (START, DATA or STOP)
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - num=16'h0000; byte_valid=0; frame_err=0; busy=0.
//     - Both rx synchroniser flops=1; state=IDLE; all counters=0.
//   - rx passes through a 2-flop synchroniser, giving rx_s; all decisions use rx_s only.
//   - Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), DIV>=2.
//     - Counter width $clog2(DIV); counts 0..DIV-1, wraps to 0.
//     - tick is high for 1 clk on the wrap.
//     - Runs freely; no re-phasing on the start edge (max 1-tick phase error allowed).
//   - FSM states: IDLE, START, DATA, STOP, BREAK. A 4-bit sample counter (scnt) is
//     advanced on each tick.
//     - IDLE: when rx_s==0, go to START with scnt=0. busy=1 from the next clk.
//     - START: at tick with scnt==7 (mid start bit):
//       - rx_s==1: false start; go to IDLE, busy=0, no other output changes.
//       - rx_s==0: clear scnt, go to DATA.
//     - DATA: at each tick with scnt==15 (mid bit), shift rx_s into sr[7] (LSB first).
//       After the 8th sample, go to STOP. A 3-bit counter (bcnt) counts bits 0..7.
//     - STOP: at tick with scnt==15, sample rx_s.
//       - rx_s==1: num<={num[7:0],sr}; byte_valid=1 for exactly that clk; frame_err=0;
//         go to IDLE.
//       - rx_s==0: frame_err=1; num unchanged; no byte_valid; go to BREAK.
//     - BREAK: stay until rx_s==1, then go to IDLE. busy=0 in BREAK.
//   - Latency: byte_valid and the num update occur on the clk edge after the mid-stop
//     tick, about 9.5 bit times after the start edge, plus 2 clk for the synchroniser.
//   - Back-to-back frames: IDLE is entered at mid-stop, so a start edge right at the end
//     of the stop bit is caught. No idle gap is needed.
//   - num changes only on a byte_valid clk. The display samples it at any time; no
//     handshake. num is held when frames are invalid.
//   - Reset during a frame aborts it completely. The next full frame after rst_n rises
//     is received normally.
// STRUCTURE
//   - Shared header uart_defs.vh holds:
//     - state localparams (IDLE=0, START=1, DATA=2, STOP=3, BREAK=4)
//     - OVERSAMPLE=16
//     - MID_START=7
//   - One sub-module: baud_tick_gen (params CLK_FREQ, BAUD, OVERSAMPLE;
//     ports clk, rst_n, tick).
//   - Synchroniser, FSM, shift register and output registers are in this module.
// TESTING (CLK_FREQ=1_600_000, BAUD=10_000 -> DIV=10, 1 bit = 160 clk)
//   1. rst_n=0, rx=1, then release -> num=16'h0000, byte_valid=0, frame_err=0, busy=0.
//   2. Frames 0x12 then 0x34 with idle gaps -> num 16'h0012 then 16'h1234;
//      byte_valid pulses 1 clk each.
//   3. rx low for 40 clk (shorter than half a bit), then high -> busy goes 1 then 0,
//      no byte_valid, num unchanged.
//   4. 0xAB with stop=0, rx held low 20 bit times, then good 0x56:
//      - after the bad frame: frame_err=1, num unchanged, no byte_valid during the break
//      - after 0x56: frame_err=0, num[7:0]=8'h56
//   5. 0x00 and 0xFF sent back-to-back (next start edge directly after the stop bit)
//      -> num=16'h00FF, two byte_valid pulses.
//   6. rst_n pulsed low during data bit 3 of a frame, then full frame 0x7E:
//      - during reset: all outputs at reset values
//      - after 0x7E: num=16'h007E

Source files
------------

// File: rtl/uart_rx_display_pkg.sv
// Shared definitions for the 8N1 receiver feeding the hex display.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_display_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam logic [3:0] MID_START  = 4'd7;
    localparam logic [3:0] MID_BIT    = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick: one-clk pulse every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
// Latency: tick asserted combinationally in the last count of each period.
// Backpressure: none; never re-phased.
module baud_tick_gen #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int             CW   = $clog2(DIV);
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_display.sv
// 8N1 UART receiver; each good byte shifts into num = {previous byte, latest byte}.
// Latency: num/byte_valid update one clk after the mid-stop tick (~9.5 bits + 2 clk sync).
// Backpressure: none; display samples num freely, frames with a bad stop bit are dropped.
module uart_rx_display
    import uart_rx_display_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] num,
    output logic        byte_valid,
    output logic        frame_err,
    output logic        busy
);

    logic      rx_meta, rx_s;
    logic      tick;
    rx_state_t state, state_nxt;
    logic [3:0] scnt;
    logic [2:0] bcnt;
    logic [7:0] sr;
    logic      scnt_clr, shift_en, load, err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_clr  = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
        err_set   = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    scnt_clr  = 1'b1;
                end
            end
            START: begin
                busy = 1'b1;
                // A start bit that is high again at its midpoint was a glitch.
                if (tick && scnt == MID_START) begin
                    scnt_clr  = 1'b1;
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                busy = 1'b1;
                if (tick && scnt == MID_BIT) begin
                    shift_en = 1'b1;
                    if (bcnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                busy = 1'b1;
                if (tick && scnt == MID_BIT) begin
                    if (rx_s) begin
                        load      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_set   = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // scnt wraps 15->0 by itself, so each data/stop bit starts at 0 with no explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            bcnt <= '0;
            sr   <= '0;
        end else begin
            if (scnt_clr) begin
                scnt <= '0;
                bcnt <= '0;
            end else begin
                if (tick) begin
                    scnt <= scnt + 1'b1;
                end
                if (shift_en) begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            if (shift_en) begin
                sr <= {rx_s, sr[7:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num        <= 16'h0000;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= load;
            if (load) begin
                num       <= {num[7:0], sr};
                frame_err <= 1'b0;
            end else if (err_set) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_display.sv
// Bench for uart_rx_display: serial frames in, scoreboard of expected display words out.
module tb_uart_rx_display;

    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int BIT      = 160;
    localparam int LAT_MIN  = 1505;
    localparam int LAT_MAX  = 1535;

    typedef struct {
        logic [7:0]  d;
        int unsigned t;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [15:0] num;
    logic        byte_valid;
    logic        frame_err;
    logic        busy;

    int unsigned cyc;
    int          n_chk;
    int          n_fail;
    int          bv_count;
    logic        prev_bv;
    logic [15:0] model_num;
    exp_t        exp_q[$];

    uart_rx_display #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .num        (num),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: the display word is the last two good bytes; each good frame yields one
    // byte_valid pulse about 9.5 bit times after its start edge.
    initial begin
        prev_bv   = 1'b0;
        model_num = 16'h0000;
        bv_count  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_num = 16'h0000;
                exp_q.delete();
                chk("reset_outputs", {13'd0, byte_valid, frame_err, busy}, 32'd0);
                chk("reset_num", 32'(num), 32'(model_num));
            end else if (byte_valid) begin
                bv_count++;
                chk("bv_single_pulse", 32'(prev_bv), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int unsigned lat;
                    e         = exp_q.pop_front();
                    lat       = cyc - e.t;
                    model_num = {model_num[7:0], e.d};
                    chk("num_on_valid", 32'(num), 32'(model_num));
                    chk("frame_err_cleared", 32'(frame_err), 32'd0);
                    n_chk++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        n_fail++;
                        $display("FAIL latency: got %0d clk required %0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                end
            end else begin
                chk("num_hold", 32'(num), 32'(model_num));
            end
            prev_bv = byte_valid;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        exp_t e;
        if (stop_ok) begin
            e.d = d;
            e.t = cyc;
            exp_q.push_back(e);
        end
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = stop_ok;
        wait_clk(BIT);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            wait_clk(1);
            t++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int   bv0;
        int   seen;
        logic [7:0] d;
        logic bad;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        rx     = 1'b1;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);

        chk("rst_num", 32'(num), 32'h0000);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Two frames with idle gaps
        bv0 = bv_count;
        send_frame(8'h12, 1'b1);
        wait_drain();
        chk("num_after_12", 32'(num), 32'h0012);
        wait_clk(2 * BIT);
        send_frame(8'h34, 1'b1);
        wait_drain();
        chk("num_after_34", 32'(num), 32'h1234);
        chk("bv_count_two", 32'(bv_count - bv0), 32'd2);
        wait_clk(BIT);

        // Glitch shorter than half a bit
        bv0  = bv_count;
        seen = 0;
        rx   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) seen = 1;
            wait_clk(1);
        end
        rx = 1'b1;
        chk("false_start_busy_rise", 32'(seen), 32'd1);
        wait_clk(2 * BIT);
        chk("false_start_busy_fall", 32'(busy), 32'd0);
        chk("false_start_no_valid", 32'(bv_count - bv0), 32'd0);
        chk("false_start_num", 32'(num), 32'h1234);

        // Bad stop bit followed by a long break, then a good byte
        send_frame(8'hAB, 1'b0);
        wait_clk(19 * BIT);
        chk("break_frame_err", 32'(frame_err), 32'd1);
        chk("break_busy", 32'(busy), 32'd0);
        chk("break_num", 32'(num), 32'h1234);
        rx = 1'b1;
        wait_clk(BIT);
        send_frame(8'h56, 1'b1);
        wait_drain();
        chk("after_56_frame_err", 32'(frame_err), 32'd0);
        chk("after_56_low_byte", 32'(num[7:0]), 32'h56);
        wait_clk(BIT);

        // Back-to-back frames, no idle gap
        bv0 = bv_count;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain();
        chk("b2b_num", 32'(num), 32'h00FF);
        chk("b2b_bv_count", 32'(bv_count - bv0), 32'd2);
        wait_clk(BIT);

        // Reset in the middle of data bit 3
        d  = 8'hA5;
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = d[3];
        wait_clk(BIT / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clk(20);
        chk("midframe_rst_num", 32'(num), 32'h0000);
        chk("midframe_rst_flags", {29'd0, byte_valid, frame_err, busy}, 32'd0);
        rst_n = 1'b1;
        wait_clk(2 * BIT);
        send_frame(8'h7E, 1'b1);
        wait_drain();
        chk("after_rst_7E", 32'(num), 32'h007E);
        wait_clk(BIT);

        // Randomized traffic: random bytes, gaps, back-to-back runs and bad stop bits
        for (int k = 0; k < 16; k++) begin
            d   = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad);
            if (bad) begin
                wait_clk(BIT * $urandom_range(2, 4));
                rx = 1'b1;
                wait_clk(BIT);
                chk("rand_frame_err", 32'(frame_err), 32'd1);
                chk("rand_break_busy", 32'(busy), 32'd0);
            end else if ($urandom_range(0, 3) != 0) begin
                wait_clk($urandom_range(1, 300));
            end
        end
        wait_drain();
        wait_clk(BIT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
